// File: rtl/cp0_core.sv
// rtl/cp0_core.sv - coprocessor-0 state, exception/ERET bookkeeping, timer, interrupts and TLB register path
module cp0_core #(
  parameter int TLBNUM    = 16,
  parameter int IDXW      = 4,
  parameter int TIMER_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      ext_int,
  input  logic            ex_valid,
  input  logic [4:0]      ex_code,
  input  logic            ex_bd,
  input  logic [31:0]     ex_pc,
  input  logic [31:0]     ex_badvaddr,
  input  logic            ex_refill,
  input  logic            eret,
  input  logic            mtc0_we,
  input  logic [7:0]      cp0_addr,
  input  logic [31:0]     cp0_wdata,
  output logic [31:0]     cp0_rdata,
  input  logic            tlbp,
  input  logic            tlbp_found,
  input  logic [IDXW-1:0] tlbp_index,
  input  logic            tlbr,
  input  logic            tlbwi,
  input  logic            tlbwr,
  input  logic [77:0]     r_entry,
  output logic [IDXW-1:0] r_index,
  output logic            w_we,
  output logic [IDXW-1:0] w_index,
  output logic [77:0]     w_entry,
  output logic [26:0]     entryhi_out,
  output logic            has_int,
  output logic [31:0]     ex_target
);
  localparam int DIVW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [7:0] A_INDEX    = 8'h00;
  localparam logic [7:0] A_RANDOM   = 8'h08;
  localparam logic [7:0] A_ENTRYLO0 = 8'h10;
  localparam logic [7:0] A_ENTRYLO1 = 8'h18;
  localparam logic [7:0] A_WIRED    = 8'h30;
  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_ENTRYHI  = 8'h50;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  logic [7:0]      im;
  logic            exl, ie;
  logic            bd, ti;
  logic [7:2]      ip_hw;
  logic [1:0]      ip_sw;
  logic [4:0]      exc_code;
  logic [31:0]     count, compare, epc, badvaddr;
  logic [DIVW-1:0] div_cnt;
  logic [IDXW-1:0] random, index;
  logic            index_p;
  logic [18:0]     vpn2;
  logic [7:0]      asid;
  logic [29:0]     lo0, lo1;

  // An exception swallows every other strobe; ERET and TLB reads outrank MTC0.
  logic do_eret, do_tlbp, do_tlbr, do_mtc0;
  assign do_eret = eret & ~ex_valid;
  assign do_tlbp = tlbp & ~ex_valid;
  assign do_tlbr = tlbr & ~ex_valid;
  assign do_mtc0 = mtc0_we & ~ex_valid & ~eret & ~tlbp & ~tlbr;

  logic wr_index, wr_lo0, wr_lo1, wr_wired, wr_count, wr_entryhi;
  logic wr_compare, wr_status, wr_cause, wr_epc;
  assign wr_index   = do_mtc0 && (cp0_addr == A_INDEX);
  assign wr_lo0     = do_mtc0 && (cp0_addr == A_ENTRYLO0);
  assign wr_lo1     = do_mtc0 && (cp0_addr == A_ENTRYLO1);
  assign wr_wired   = do_mtc0 && (cp0_addr == A_WIRED);
  assign wr_count   = do_mtc0 && (cp0_addr == A_COUNT);
  assign wr_entryhi = do_mtc0 && (cp0_addr == A_ENTRYHI);
  assign wr_compare = do_mtc0 && (cp0_addr == A_COMPARE);
  assign wr_status  = do_mtc0 && (cp0_addr == A_STATUS);
  assign wr_cause   = do_mtc0 && (cp0_addr == A_CAUSE);
  assign wr_epc     = do_mtc0 && (cp0_addr == A_EPC);

  logic code_tlb, code_bad;
  assign code_tlb = (ex_code == 5'd1) | (ex_code == 5'd2) | (ex_code == 5'd3);
  assign code_bad = code_tlb | (ex_code == 5'd4) | (ex_code == 5'd5);

  // TI compares against the Count value being loaded, so it rises together with the match.
  logic        div_wrap, ti_next;
  logic [31:0] count_next;
  assign div_wrap   = (div_cnt == DIVW'(TIMER_DIV - 1));
  assign count_next = wr_count ? cp0_wdata : (div_wrap ? count + 32'd1 : count);
  assign ti_next    = wr_compare ? 1'b0 : (ti | (count_next == compare));

  always_ff @(posedge clk) begin
    if (reset) begin
      im <= '0; exl <= 1'b0; ie <= 1'b0;
      bd <= 1'b0; ti <= 1'b0; ip_hw <= '0; ip_sw <= '0; exc_code <= '0;
      count <= '0; compare <= 32'hFFFF_FFFF; epc <= '0; badvaddr <= '0;
      div_cnt <= '0; random <= IDXW'(TLBNUM - 1);
      index <= '0; index_p <= 1'b0;
      vpn2 <= '0; asid <= '0; lo0 <= '0; lo1 <= '0;
    end else begin
      div_cnt <= (wr_count || div_wrap) ? '0 : div_cnt + DIVW'(1);
      count   <= count_next;
      ti      <= ti_next;
      ip_hw   <= {ext_int[5] | ti_next, ext_int[4:0]};
      if (wr_compare) compare <= cp0_wdata;
      random  <= wr_wired ? IDXW'(TLBNUM - 1) : random - IDXW'(1);

      if (ex_valid) exl <= 1'b1;
      else if (do_eret) exl <= 1'b0;
      else if (wr_status) exl <= cp0_wdata[1];
      if (wr_status) begin
        im <= cp0_wdata[15:8];
        ie <= cp0_wdata[0];
      end

      if (ex_valid) begin
        exc_code <= ex_code;
        if (!exl) begin
          bd  <= ex_bd;
          epc <= ex_bd ? ex_pc - 32'd4 : ex_pc;
        end
        if (code_bad) badvaddr <= ex_badvaddr;
      end else if (wr_epc) begin
        epc <= cp0_wdata;
      end
      if (wr_cause) ip_sw <= cp0_wdata[9:8];

      if (ex_valid && code_tlb) begin
        vpn2 <= ex_badvaddr[31:13];
      end else if (do_tlbr) begin
        vpn2 <= r_entry[77:59];
        asid <= r_entry[58:51];
      end else if (wr_entryhi) begin
        vpn2 <= cp0_wdata[31:13];
        asid <= cp0_wdata[7:0];
      end

      if (do_tlbr) begin
        lo0 <= {4'b0, r_entry[49:25], r_entry[50]};
        lo1 <= {4'b0, r_entry[24:0], r_entry[50]};
      end else begin
        if (wr_lo0) lo0 <= cp0_wdata[29:0];
        if (wr_lo1) lo1 <= cp0_wdata[29:0];
      end

      if (do_tlbp) begin
        index_p <= ~tlbp_found;
        if (tlbp_found) index <= tlbp_index;
      end else if (wr_index) begin
        index_p <= 1'b0;
        index   <= cp0_wdata[IDXW-1:0];
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_INDEX:    cp0_rdata = {index_p, {(31-IDXW){1'b0}}, index};
      A_RANDOM:   cp0_rdata = {{(32-IDXW){1'b0}}, random};
      A_ENTRYLO0: cp0_rdata = {2'b0, lo0};
      A_ENTRYLO1: cp0_rdata = {2'b0, lo1};
      A_BADVADDR: cp0_rdata = badvaddr;
      A_COUNT:    cp0_rdata = count;
      A_ENTRYHI:  cp0_rdata = {vpn2, 5'b0, asid};
      A_COMPARE:  cp0_rdata = compare;
      A_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      A_CAUSE:    cp0_rdata = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
      A_EPC:      cp0_rdata = epc;
      default:    cp0_rdata = '0;
    endcase
  end

  always_comb begin
    ex_target = '0;
    if (ex_valid) ex_target = (ex_refill && !exl) ? 32'hBFC0_0200 : 32'hBFC0_0380;
    else if (eret) ex_target = epc;
  end

  assign has_int     = (|({ip_hw, ip_sw} & im)) & ie & ~exl;
  assign r_index     = index;
  assign w_we        = (tlbwi | tlbwr) & ~ex_valid;
  assign w_index     = tlbwr ? random : index;
  assign entryhi_out = {vpn2, asid};
  assign w_entry     = {vpn2, asid, lo0[0] & lo1[0], lo0[25:6], lo0[5:3], lo0[2], lo0[1],
                        lo1[25:6], lo1[5:3], lo1[2], lo1[1]};
endmodule
